// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and coordinate type for the beam scheduler
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/vga_raster_counter.sv
// rtl/vga_raster_counter.sv - wrapping x/y raster counter pair with configurable reset position
//
// Ports:
//   clk, rst_n  pixel clock, asynchronous active-low reset
//   ena         advance enable; low holds the position
//   x, y        current position (registered)
//   x_nxt,y_nxt position the counter moves to on the next enabled edge
module vga_raster_counter
    import vga_timing_pkg::*;
#(
    parameter int X_TOTAL = H_TOTAL_DEF,
    parameter int Y_TOTAL = V_TOTAL_DEF,
    parameter int X_START = H_TOTAL_DEF - 1,
    parameter int Y_START = V_TOTAL_DEF - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] x_nxt,
    output logic [COORD_W-1:0] y_nxt
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(X_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(Y_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_INIT  = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_INIT  = COORD_W'(Y_START);

    always_comb begin
        x_nxt = x + 1'b1;
        y_nxt = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_INIT;
            y <= Y_INIT;
        end else if (ena) begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/vga_beam_scheduler.sv
// rtl/vga_beam_scheduler.sv - VGA raster timing with PIPE_LAT-cycle lookahead fetch coordinates
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   ena                 advance enable; low freezes every register
//   hpos, vpos          current beam position
//   hsync, vsync        active-low syncs
//   display_on          beam inside the visible area
//   fetch_x, fetch_y    position PIPE_LAT cycles ahead of the beam
//   fetch_on            fetch position is visible
//   line_start          one-cycle pulse at hpos==0
//   frame_start         one-cycle pulse at (0,0)
//   frame_cnt           frame counter, present only when VGA_FRAME_CNT_EN is defined, else 0
module vga_beam_scheduler
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [COORD_W-1:0] hpos,
    output logic [COORD_W-1:0] vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [COORD_W-1:0] fetch_x,
    output logic [COORD_W-1:0] fetch_y,
    output logic               fetch_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Fetch counter starts where the beam reset position lands after PIPE_LAT steps.
    // PIPE_LAT < H_TOTAL, so at most one line wrap (which is also the frame wrap).
    localparam int F_X_START = (H_TOTAL - 1 + PIPE_LAT) % H_TOTAL;
    localparam int F_Y_START = (PIPE_LAT >= 1) ? 0 : V_TOTAL - 1;

    localparam logic [COORD_W-1:0] HA     = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VA     = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    coord_t beam_nxt;
    coord_t fetch_nxt;

    vga_raster_counter #(
        .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL),
        .X_START(H_TOTAL - 1), .Y_START(V_TOTAL - 1)
    ) u_beam (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .x(hpos), .y(vpos),
        .x_nxt(beam_nxt.x), .y_nxt(beam_nxt.y)
    );

    vga_raster_counter #(
        .X_TOTAL(H_TOTAL), .Y_TOTAL(V_TOTAL),
        .X_START(F_X_START), .Y_START(F_Y_START)
    ) u_fetch (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .x(fetch_x), .y(fetch_y),
        .x_nxt(fetch_nxt.x), .y_nxt(fetch_nxt.y)
    );

    // Flags are decoded from the next positions so that, once registered, they
    // line up with the counter values loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b0;
            fetch_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ena) begin
            hsync       <= !((beam_nxt.x >= HS_BEG) && (beam_nxt.x < HS_END));
            vsync       <= !((beam_nxt.y >= VS_BEG) && (beam_nxt.y < VS_END));
            display_on  <= (beam_nxt.x < HA) && (beam_nxt.y < VA);
            fetch_on    <= (fetch_nxt.x < HA) && (fetch_nxt.y < VA);
            line_start  <= (beam_nxt.x == '0);
            frame_start <= (beam_nxt.x == '0) && (beam_nxt.y == '0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (ena && (beam_nxt.x == '0) && (beam_nxt.y == '0)) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_beam_scheduler.sv
// tb/tb_vga_beam_scheduler.sv - self-checking bench for vga_beam_scheduler against a linear-index raster model
module tb_vga_beam_scheduler;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 20, VFP = 3, VS = 2, VBP = 5;
    localparam int PL = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int NPIX = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [9:0] hpos, vpos, fetch_x, fetch_y;
    logic       hsync, vsync, display_on, fetch_on, line_start, frame_start;
    logic [7:0] frame_cnt;
    logic [53:0] dut_vec;

    int total = 0;
    int bad = 0;
    int adv = 0;

    always #5 clk = ~clk;

    vga_beam_scheduler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .fetch_x(fetch_x), .fetch_y(fetch_y),
        .fetch_on(fetch_on), .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    assign dut_vec = {hpos, vpos, fetch_x, fetch_y, hsync, vsync, display_on,
                      fetch_on, line_start, frame_start, frame_cnt};

    // Reference: after 'a' enabled edges the beam sits at linear raster index a-1 (mod NPIX),
    // with reset corresponding to index -1; the fetch point is PL indices further on.
    function automatic int lin_of(int a);
        return (a + NPIX - 1) % NPIX;
    endfunction

    function automatic logic [53:0] model_vec(int a);
        int l, h, v, fl, fx, fy, nf;
        logic hs_o, vs_o, dsp, fon, ls, fs;
        logic [7:0] fc;
        l    = lin_of(a);
        h    = l % HT;
        v    = l / HT;
        fl   = (l + PL) % NPIX;
        fx   = fl % HT;
        fy   = fl / HT;
        hs_o = !(h >= HA + HFP && h < HA + HFP + HS);
        vs_o = !(v >= VA + VFP && v < VA + VFP + VS);
        dsp  = (h < HA) && (v < VA);
        fon  = (a > 0) && (fx < HA) && (fy < VA);
        ls   = (a > 0) && (h == 0);
        fs   = (a > 0) && (l == 0);
        nf   = (a == 0) ? 0 : ((a - 1) / NPIX + 1);
`ifdef VGA_FRAME_CNT_EN
        fc = 8'(nf % 256);
`else
        fc = 8'(nf * 0);
`endif
        return {10'(h), 10'(v), 10'(fx), 10'(fy), hs_o, vs_o, dsp, fon, ls, fs, fc};
    endfunction

    task automatic tick(input logic e);
        ena = e;
        @(posedge clk);
        #1;
        if (e && rst_n) adv++;
    endtask

    task automatic run_to(input int target);
        int n;
        n = (target - lin_of(adv) + NPIX) % NPIX;
        repeat (n) tick(1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena   = 1'b0;
        adv   = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (hpos !== 10'(HT - 1) || vpos !== 10'(VT - 1)) begin
            bad++;
            $display("FAIL reset_pos got=(%0d,%0d) want=(%0d,%0d)", hpos, vpos, HT - 1, VT - 1);
        end
        total++;
        if (fetch_x !== 10'(PL - 1) || fetch_y !== 10'd0) begin
            bad++;
            $display("FAIL reset_fetch got=(%0d,%0d) want=(%0d,0)", fetch_x, fetch_y, PL - 1);
        end
        total++;
        if ({hsync, vsync, display_on, fetch_on, line_start, frame_start, frame_cnt} !== {6'b110000, 8'd0}) begin
            bad++;
            $display("FAIL reset_flags got=%b_%h want=110000_00",
                     {hsync, vsync, display_on, fetch_on, line_start, frame_start}, frame_cnt);
        end
        total++;
        if (dut_vec !== model_vec(adv)) begin
            bad++;
            $display("FAIL reset_vec got=%h want=%h", dut_vec, model_vec(adv));
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        total++;
        if (hpos !== 10'd0 || vpos !== 10'd0 || {frame_start, line_start, display_on, hsync, vsync} !== 5'b11111) begin
            bad++;
            $display("FAIL first_edge got=(%0d,%0d) fs/ls/de/hs/vs=%b want=(0,0) 11111", hpos, vpos,
                     {frame_start, line_start, display_on, hsync, vsync});
        end
    endtask

    task automatic test_line;
        int low_cnt = 0, first_low = -1, ls_cnt = 0, errs = 0;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1);
            if (!hsync) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(hpos);
            end
            if (line_start) ls_cnt++;
            if (dut_vec !== model_vec(adv)) errs++;
        end
        total++;
        if (low_cnt != HS) begin bad++; $display("FAIL hsync_width got=%0d want=%0d", low_cnt, HS); end
        total++;
        if (first_low != HA + HFP) begin bad++; $display("FAIL hsync_start got=%0d want=%0d", first_low, HA + HFP); end
        total++;
        if (ls_cnt != 1) begin bad++; $display("FAIL line_start_per_line got=%0d want=1", ls_cnt); end
        total++;
        if (errs != 0) begin bad++; $display("FAIL line_model got=%0d mismatching cycles want=0", errs); end
    endtask

    task automatic test_frame;
        int fs_cnt = 0, de_cnt = 0, vs_cnt = 0, vs_min = 9999, vs_max = -1, errs = 0;
        for (int i = 0; i < NPIX; i++) begin
            tick(1'b1);
            if (frame_start) fs_cnt++;
            if (display_on) de_cnt++;
            if (!vsync) begin
                vs_cnt++;
                if (int'(vpos) < vs_min) vs_min = int'(vpos);
                if (int'(vpos) > vs_max) vs_max = int'(vpos);
            end
            if (dut_vec !== model_vec(adv)) errs++;
        end
        total++;
        if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_per_frame got=%0d want=1", fs_cnt); end
        total++;
        if (de_cnt != HA * VA) begin bad++; $display("FAIL display_on_count got=%0d want=%0d", de_cnt, HA * VA); end
        total++;
        if (vs_min != VA + VFP || vs_max != VA + VFP + VS - 1 || vs_cnt != VS * HT) begin
            bad++;
            $display("FAIL vsync_lines got=%0d..%0d cnt=%0d want=%0d..%0d cnt=%0d", vs_min, vs_max, vs_cnt,
                     VA + VFP, VA + VFP + VS - 1, VS * HT);
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL frame_model got=%0d mismatching cycles want=0", errs); end
    endtask

    task automatic test_lookahead;
        run_to(9 * HT + HT - 2);
        total++;
        if (hpos !== 10'(HT - 2) || fetch_x !== 10'd0 || fetch_y !== 10'd10 || fetch_on !== 1'b1) begin
            bad++;
            $display("FAIL lookahead_line got=(%0d,%0d) on=%b at h=%0d want=(0,10) on=1", fetch_x, fetch_y, fetch_on, hpos);
        end
        run_to((VT - 1) * HT + HT - 2);
        total++;
        if (vpos !== 10'(VT - 1) || fetch_x !== 10'd0 || fetch_y !== 10'd0 || fetch_on !== 1'b1) begin
            bad++;
            $display("FAIL lookahead_frame got=(%0d,%0d) on=%b at v=%0d want=(0,0) on=1", fetch_x, fetch_y, fetch_on, vpos);
        end
    endtask

    task automatic test_ena_hold;
        int errs = 0;
        run_to(((lin_of(adv) / HT + 1) % VT) * HT + 100);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            if (hpos !== 10'd100 || dut_vec !== model_vec(adv)) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL ena_hold got=%0d changed cycles want=0", errs); end
        tick(1'b1);
        total++;
        if (hpos !== 10'd101) begin bad++; $display("FAIL ena_resume got=%0d want=101", hpos); end
    endtask

    task automatic test_random_ena;
        int errs = 0;
        logic [53:0] first_got = '0, first_want = '0;
        for (int i = 0; i < 8000; i++) begin
            tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (dut_vec !== model_vec(adv)) begin
                if (errs == 0) begin first_got = dut_vec; first_want = model_vec(adv); end
                errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL random_ena got=%0d mismatches first=%h want=%h", errs, first_got, first_want);
        end
    endtask

    task automatic test_async_reset;
        repeat (37) tick(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        adv = 0;
        total++;
        if (dut_vec !== model_vec(0)) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", dut_vec, model_vec(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        total++;
        if (frame_start !== 1'b1 || hpos !== 10'd0 || vpos !== 10'd0 || dut_vec !== model_vec(adv)) begin
            bad++;
            $display("FAIL after_reset got=%h want=%h", dut_vec, model_vec(adv));
        end
    endtask

    initial begin
        test_reset;
        test_line;
        test_frame;
        test_lookahead;
        test_ena_hold;
        test_random_ena;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
